// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 select mux. Registers a one-hot
// grant and the matching select pair; an owner may hold the mux up to MAX_HOLD
// cycles while someone else is waiting.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel0,
    output logic       sel1,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [1:0] last_q, last_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] win;
    logic [3:0] others;
    logic       do_grant;

    // First set bit in the order ptr+1, ptr+2, ptr+3, ptr. Scanning from the
    // far end lets the nearest hit overwrite the rest.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    // While in GRANT the owner is always last_q, so gnt_q is its one-hot mask.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        win        = rr_pick(req, last_q);
        others     = req & ~gnt_q;
        do_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) do_grant = 1'b1;
            end
            GRANT: begin
                if (req[last_q]) begin
                    if ((hold_cnt_q < HOLD_LAST) || (others == 4'b0000)) begin
                        if (hold_cnt_q < HOLD_LAST) hold_cnt_d = hold_cnt_q + 4'd1;
                    end else begin
                        do_grant = 1'b1;
                    end
                end else if (|req) begin
                    do_grant = 1'b1;
                end else begin
                    // Select pair is left alone so the mux output stays put.
                    state_d    = IDLE;
                    gnt_d      = 4'b0000;
                    busy_d     = 1'b0;
                    hold_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d    = GRANT;
            gnt_d      = 4'b0001 << win;
            sel_d      = win;
            busy_d     = 1'b1;
            last_d     = win;
            hold_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'b00;
            busy_q     <= 1'b0;
            last_q     <= 2'd3;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel0 = sel_q[0];
    assign sel1 = sel_q[1];
    assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and random checks of mux4_rr_arbiter at MAX_HOLD=1 and MAX_HOLD=4.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req1, req4;
    logic [3:0] gnt1, gnt4;
    logic       s0_1, s1_1, busy1;
    logic       s0_4, s1_4, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    mux4_rr_arbiter #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
        .sel0(s0_1), .sel1(s1_1), .busy(busy1)
    );

    mux4_rr_arbiter #(.MAX_HOLD(4)) u_h4 (
        .clk(clk), .rst(rst), .req(req4), .gnt(gnt4),
        .sel0(s0_4), .sel1(s1_4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req1 = 4'b0000;
        req4 = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({gnt4, s1_4, s0_4, busy4} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL reset_h4 got gnt=%b sel=%b%b busy=%b exp 0000 00 0", gnt4, s1_4, s0_4, busy4);
        end
        n_checks++;
        if ({gnt1, s1_1, s0_1, busy1} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL reset_h1 got gnt=%b sel=%b%b busy=%b exp 0000 00 0", gnt1, s1_1, s0_1, busy1);
        end
    endtask

    task automatic test_single();
        req4 = 4'b0100;
        tick();
        n_checks++;
        if ({gnt4, s1_4, s0_4, busy4} !== 7'b0100_10_1) begin
            n_fail++;
            $display("FAIL single_grant got gnt=%b sel=%b%b busy=%b exp 0100 10 1", gnt4, s1_4, s0_4, busy4);
        end
        req4 = 4'b0000;
        tick();
        n_checks++;
        if ({gnt4, s1_4, s0_4, busy4} !== 7'b0000_10_0) begin
            n_fail++;
            $display("FAIL single_release got gnt=%b sel=%b%b busy=%b exp 0000 10 0", gnt4, s1_4, s0_4, busy4);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g [5];
        logic [1:0] exp_s [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_s = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        do_reset();
        req1 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (gnt1 !== exp_g[i] || {s1_1, s0_1} !== exp_s[i]) begin
                n_fail++;
                $display("FAIL rotate_%0d got gnt=%b sel=%b%b exp %b %b", i, gnt1, s1_1, s0_1, exp_g[i], exp_s[i]);
            end
        end
        req1 = 4'b0000;
    endtask

    task automatic test_hold();
        do_reset();
        req4 = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (gnt4 !== 4'b0001) begin
                n_fail++;
                $display("FAIL hold_alone_%0d got gnt=%b exp 0001", i, gnt4);
            end
        end
        req4 = 4'b0101;
        tick();
        n_checks++;
        if (gnt4 !== 4'b0100 || {s1_4, s0_4} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_late_req got gnt=%b sel=%b%b exp 0100 10", gnt4, s1_4, s0_4);
        end

        do_reset();
        req4 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (gnt4 !== 4'b0001) begin
                n_fail++;
                $display("FAIL hold_tenure_%0d got gnt=%b exp 0001", i, gnt4);
            end
        end
        tick();
        n_checks++;
        if (gnt4 !== 4'b0100) begin
            n_fail++;
            $display("FAIL hold_expire got gnt=%b exp 0100", gnt4);
        end
        req4 = 4'b0000;
    endtask

    task automatic test_handoff();
        do_reset();
        req4 = 4'b0010;
        tick();
        req4 = 4'b0110;
        tick();
        n_checks++;
        if (gnt4 !== 4'b0010) begin
            n_fail++;
            $display("FAIL handoff_owner got gnt=%b exp 0010", gnt4);
        end
        req4 = 4'b0100;
        tick();
        n_checks++;
        if (gnt4 !== 4'b0100 || {s1_4, s0_4} !== 2'b10 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_direct got gnt=%b sel=%b%b busy=%b exp 0100 10 1", gnt4, s1_4, s0_4, busy4);
        end
        req4 = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req4 = 4'b1000;
        tick();
        req4 = 4'b1111;
        tick();
        n_checks++;
        if (gnt4 !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_owner got gnt=%b exp 1000", gnt4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({gnt4, s1_4, s0_4, busy4} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL midrst_clear got gnt=%b sel=%b%b busy=%b exp 0000 00 0", gnt4, s1_4, s0_4, busy4);
        end
        tick();
        n_checks++;
        if (gnt4 !== 4'b0001 || {s1_4, s0_4} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_regrant got gnt=%b sel=%b%b exp 0001 00", gnt4, s1_4, s0_4);
        end
        req4 = 4'b0000;
    endtask

    // Requests flip with probability 1/8 per bit so long continuous requests occur.
    task automatic test_random();
        int wait1 [4];
        int wait4 [4];
        logic [3:0] g;
        logic [1:0] s;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait1[i] = 0;
            wait4[i] = 0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) req1[b] = ~req1[b];
                if ($urandom_range(7) == 0) req4[b] = ~req4[b];
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                g = (d == 0) ? gnt1 : gnt4;
                s = (d == 0) ? {s1_1, s0_1} : {s1_4, s0_4};
                n_checks++;
                if ((g & (g - 4'd1)) !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rand_onehot dut%0d cyc %0d got gnt=%b exp onehot or zero", d, cyc, g);
                end
                n_checks++;
                if (((d == 0) ? busy1 : busy4) !== (|g)) begin
                    n_fail++;
                    $display("FAIL rand_busy dut%0d cyc %0d got busy=%b exp %b", d, cyc, (d == 0) ? busy1 : busy4, |g);
                end
                if (|g) begin
                    n_checks++;
                    if (g !== (4'b0001 << s)) begin
                        n_fail++;
                        $display("FAIL rand_sel dut%0d cyc %0d got sel=%b gnt=%b", d, cyc, s, g);
                    end
                end
            end
            for (int b = 0; b < 4; b++) begin
                wait1[b] = (req1[b] && !gnt1[b]) ? wait1[b] + 1 : 0;
                wait4[b] = (req4[b] && !gnt4[b]) ? wait4[b] + 1 : 0;
                n_checks++;
                if (wait1[b] > 3 * 1 + 3) begin
                    n_fail++;
                    $display("FAIL rand_starve_h1 req %0d cyc %0d waited %0d exp <= 6", b, cyc, wait1[b]);
                end
                n_checks++;
                if (wait4[b] > 3 * 4 + 3) begin
                    n_fail++;
                    $display("FAIL rand_starve_h4 req %0d cyc %0d waited %0d exp <= 15", b, cyc, wait4[b]);
                end
            end
        end
        req1 = 4'b0000;
        req4 = 4'b0000;
    endtask

    initial begin
        rst  = 1'b1;
        req1 = 4'b0000;
        req4 = 4'b0000;
        test_reset();
        test_single();
        test_rotate();
        test_hold();
        test_handoff();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
